// File: rtl/row_renderer.sv
// Double-buffered scan-line renderer: fills the back line bank from a square-tiled board.
// Optional build macro GRID_LINES_EN draws a 24'h202020 grid on square borders.
module row_renderer #(
  parameter int WIDTH_PX  = 480,
  parameter int ROWS      = 480,
  parameter int SQUARE_PX = 32
) (
  input  logic        clock_vga,
  input  logic        reset,
  input  logic        next_row,
  input  logic        next_screen,
  input  logic [8:0]  address,
  output logic [23:0] data,
  output logic [3:0]  cell_x,
  output logic [3:0]  cell_y,
  input  logic [23:0] cell_color,
  output logic        busy,
  output logic        overrun
);

  localparam int COLS = WIDTH_PX / SQUARE_PX;
  localparam int AW   = $clog2(WIDTH_PX);
  localparam int LW   = $clog2(ROWS);
  localparam int PW   = (SQUARE_PX > 1) ? $clog2(SQUARE_PX) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

  state_t        state_q;
  logic          front_q;
  logic          pending_q;
  logic [LW-1:0] line_q;
  logic [PW-1:0] px_q;
  logic [AW-1:0] wr_addr_q;
  logic [3:0]    cell_x_q;
  logic [3:0]    cell_y_q;
  logic          busy_q;
  logic          overrun_q;
  logic [23:0]   data_q;

  logic [23:0]   bank_q [2][WIDTH_PX];

  logic [LW-1:0] next_line_d;
  logic [23:0]   pix_d;
  logic          wr_en_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_line_d = (line_q == LW'(ROWS - 1)) ? '0 : line_q + 1'b1;
    if (pending_q || next_screen) next_line_d = '0;
`ifdef GRID_LINES_EN
    pix_d = ((px_q == '0) || ((int'(line_q) % SQUARE_PX) == 0)) ? 24'h202020 : cell_color;
`else
    pix_d = cell_color;
`endif
    // An aborting next_row or a reset suppresses the pixel in flight.
    wr_en_d = (state_q == FILL) && !next_row && !reset;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock_vga) begin
    if (reset) begin
      state_q   <= IDLE;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      line_q    <= '0;
      px_q      <= '0;
      wr_addr_q <= '0;
      cell_x_q  <= '0;
      cell_y_q  <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (next_row) begin
      if (state_q != IDLE) overrun_q <= 1'b1;
      front_q   <= ~front_q;
      pending_q <= 1'b0;
      line_q    <= next_line_d;
      cell_y_q  <= 4'(int'(next_line_d) / SQUARE_PX);
      cell_x_q  <= '0;
      px_q      <= '0;
      wr_addr_q <= '0;
      state_q   <= FETCH;
      busy_q    <= 1'b1;
    end else begin
      if (next_screen) pending_q <= 1'b1;
      case (state_q)
        FETCH: state_q <= FILL;
        FILL: begin
          wr_addr_q <= wr_addr_q + 1'b1;
          if (px_q == PW'(SQUARE_PX - 1)) begin
            px_q <= '0;
            if (cell_x_q == 4'(COLS - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cell_x_q <= cell_x_q + 1'b1;
              state_q  <= FETCH;
            end
          end else begin
            px_q <= px_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: line banks are plain RAM and deliberately carry no reset.
  always_ff @(posedge clock_vga) begin
    if (wr_en_d) bank_q[~front_q][wr_addr_q] <= pix_d;
  end

  always_ff @(posedge clock_vga) begin
    if (reset) begin
      data_q <= '0;
    end else if (int'(address) < WIDTH_PX) begin
      data_q <= bank_q[front_q][AW'(address)];
    end else begin
      data_q <= '0;
    end
  end

  assign data    = data_q;
  assign cell_x  = cell_x_q;
  assign cell_y  = cell_y_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_row_renderer.sv
// Directed bench for row_renderer with a registered board-memory model.
module tb_row_renderer;

`ifdef GRID_LINES_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        next_row;
  logic        next_screen;
  logic [8:0]  address;
  logic [23:0] data;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic [23:0] cell_color;
  logic        busy;
  logic        overrun;
  logic        x_mode;

  int errors = 0;
  int checks = 0;

  row_renderer dut (
    .clock_vga  (clk),
    .reset      (reset),
    .next_row   (next_row),
    .next_screen(next_screen),
    .address    (address),
    .data       (data),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cell_color (cell_color),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory: one-cycle read latency.
  always @(posedge clk)
    cell_color <= x_mode ? {12'h000, cell_x, 8'h00} : 24'hFF0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input bit row, input bit scr);
    @(negedge clk);
    next_row    = row;
    next_screen = scr;
    @(negedge clk);
    next_row    = 1'b0;
    next_screen = 1'b0;
  endtask

  task automatic read_px(input int a, output logic [23:0] d);
    @(negedge clk);
    address = 9'(a);
    @(negedge clk);
    d = data;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_px(input string tag, input int a, input logic [23:0] exp);
    logic [23:0] d;
    read_px(a, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    int n;
    int bad;
    logic [23:0] d;
    reset = 1'b1; next_row = 1'b0; next_screen = 1'b0; address = '0; x_mode = 1'b0;
    do_reset();
    check("rst_data", 32'(data), 32'd0);
    check("rst_cell_x", 32'(cell_x), 32'd0);
    check("rst_cell_y", 32'(cell_y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Solid red line 0: busy length, cell_y, full-line readback.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'd495);
    check("red_cell_y", 32'(cell_y), 32'd0);
    pulse(1'b1, 1'b0);
    bad = 0;
    for (int a = 0; a < 480; a++) begin
      read_px(a, d);
      if (d !== 24'hFF0000) bad++;
    end
    check("red_line_bad", 32'(bad), 32'd0);
    check_px("red_479", 479, 24'hFF0000);
    wait_idle();
    check("no_overrun", 32'(overrun), 32'd0);

    // Column-coded colours.
    x_mode = 1'b1;
    pulse(1'b1, 1'b0);
    wait_idle();
    pulse(1'b1, 1'b0);
    check_px("x_addr31", 31, 24'h000000);
    check_px("x_addr32", 32, 24'h000100);
    check_px("x_addr479", 479, 24'h000E00);
    check_px("x_addr480", 480, 24'h000000);
    wait_idle();

    // Overrun: second next_row 100 cycles after the first.
    pulse(1'b1, 1'b0);
    repeat (99) @(negedge clk);
    check("pre_abort_cell_x", 32'(cell_x), 32'd3);
    pulse(1'b1, 1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    check("restart_cell_x", 32'(cell_x), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_idle();
    pulse(1'b1, 1'b0);
    wait_idle();
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-render.
    pulse(1'b1, 1'b0);
    repeat (50) @(negedge clk);
    do_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cell_x", 32'(cell_x), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);

    // Line wrap over 480 pulses.
    for (int i = 1; i <= 480; i++) begin
      pulse(1'b1, 1'b0);
      if (i == 32)  check("wrap_l32", 32'(cell_y), 32'd1);
      if (i == 479) check("wrap_l479", 32'(cell_y), 32'd14);
      if (i == 480) check("wrap_l0", 32'(cell_y), 32'd0);
    end
    repeat (40) pulse(1'b1, 1'b0);
    check("l40_cell_y", 32'(cell_y), 32'd1);
    pulse(1'b1, 1'b1);
    check("coincident_l0", 32'(cell_y), 32'd0);
    repeat (40) pulse(1'b1, 1'b0);
    check("l40b_cell_y", 32'(cell_y), 32'd1);
    pulse(1'b0, 1'b1);
    check("screen_hold_y", 32'(cell_y), 32'd1);
    pulse(1'b1, 1'b0);
    check("pending_l0", 32'(cell_y), 32'd0);
    wait_idle();

    // Lines 32 and 33: grid borders when enabled, plain colours otherwise.
    do_reset();
    pulse(1'b1, 1'b1);
    repeat (32) pulse(1'b1, 1'b0);
    wait_idle();
    pulse(1'b1, 1'b0);
    check_px("l32_a0", 0, GRID ? 24'h202020 : 24'h000000);
    check_px("l32_a33", 33, GRID ? 24'h202020 : 24'h000100);
    check_px("l32_a479", 479, GRID ? 24'h202020 : 24'h000E00);
    wait_idle();
    pulse(1'b1, 1'b0);
    check_px("l33_a32", 32, GRID ? 24'h202020 : 24'h000100);
    check_px("l33_a33", 33, 24'h000100);
    check_px("l33_a64", 64, GRID ? 24'h202020 : 24'h000200);
    check_px("l33_a479", 479, 24'h000E00);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/row_renderer.md
ROW_RENDERER -- requirements
Module: row_renderer

Interface
REQ-001 SHALL have parameter WIDTH_PX, default 480, visible pixels per line.
REQ-002 SHALL have parameter ROWS, default 480, visible lines per frame.
REQ-003 SHALL have parameter SQUARE_PX, default 32, square edge in pixels; WIDTH_PX and ROWS are multiples of SQUARE_PX.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clock_vga  in  1  pixel clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 next_row  in  1  one-cycle pulse: swap line banks and render the next line.
REQ-008 next_screen  in  1  one-cycle pulse: the next render is line 0.
REQ-009 address  in  9  streamer read address, pixel index within the line.
REQ-010 data  out  24  pixel {R,G,B} read from the front bank.
REQ-011 cell_x  out  4  square column requested from board memory.
REQ-012 cell_y  out  4  square row requested from board memory.
REQ-013 cell_color  in  24  board memory colour for (cell_x, cell_y), valid one cycle after request.
REQ-014 busy  out  1  high while rendering into the back bank.
REQ-015 overrun  out  1  sticky: next_row arrived while busy.

Function
REQ-016 SHALL hold two WIDTH_PX x 24 line banks; front bank read by streamer, back bank written by renderer.
REQ-017 data SHALL be registered: value of front[address] one cycle after address; address >= WIDTH_PX returns 24'h0.
REQ-018 line index L (0..ROWS-1) SHALL select cell_y = L / SQUARE_PX.
REQ-019 On next_row: swap front/back, then render line L+1 (wrap ROWS-1 -> 0) into the new back bank.
REQ-020 On next_screen: set pending flag; the next next_row renders line 0 and clears the flag.
REQ-021 next_screen and next_row in the same cycle: line 0 rendered by that next_row.
REQ-022 FSM states: IDLE, FETCH, FILL.
REQ-023 IDLE -> FETCH on next_row; FETCH drives cell_x = column C, one cycle; FILL writes SQUARE_PX pixels of cell_color to back bank, one per cycle.
REQ-024 FILL -> FETCH for C+1 after last pixel of a square; FILL -> IDLE after column WIDTH_PX/SQUARE_PX-1.
REQ-025 Defaults: 15 x (1+32) = 495 cycles per line, fits a 640-cycle line.
REQ-026 busy SHALL be high in FETCH and FILL, low in IDLE.
REQ-027 next_row while busy: set overrun, abort current line, swap, restart at column 0 of the new line.
REQ-028 overrun SHALL clear only on reset.
REQ-029 cell_x, cell_y SHALL hold their last values outside FETCH.

Reset
REQ-030 Reset SHALL set state IDLE, front = bank 0, L = 0, pending flag = 0.
REQ-031 Reset SHALL drive data 0, cell_x 0, cell_y 0, busy 0, overrun 0.
REQ-032 Bank contents are not cleared by reset.
REQ-033 Reset mid-render SHALL abandon the line; no further writes occur.

Configuration
REQ-034 With GRID_LINES_EN defined: pixel offset 0 within a square, or line offset 0 within a square row, is written as 24'h202020 instead of cell_color.
REQ-035 Without GRID_LINES_EN: every pixel is written as cell_color; cycle timing is identical in both builds.

Verification
REQ-036 Reset, next_screen, then next_row, with cell_color = 24'hFF0000 for all cells:
- busy high for 495 cycles;
- cell_y = 0;
- after the next next_row, address 0..479 reads 24'hFF0000.
REQ-037 cell_color = {8'h0, 4'h0, cell_x, 8'h0}:
- after swap, address 31 reads x=0;
- address 32 reads x=1;
- address 479 reads x=14;
- address 480 reads 24'h0.
REQ-038 Second next_row 100 cycles after the first:
- overrun = 1;
- render restarts at cell_x = 0;
- overrun stays 1 across later lines.
REQ-039 Line wrap:
- 480 next_row pulses with no next_screen wrap L to 0, cell_y = 0;
- next_screen coincident with next_row renders line 0.
REQ-040 GRID_LINES_EN build:
- line 32 is all 24'h202020;
- on line 33, address 32 reads 24'h202020 and address 33 reads cell_color.
